fp_mul_arbiter: RTL and testbench
=================================

// Module: fp_mul_arbiter
// PURPOSE
//  Shares one fp_mul_16 instance (half-precision multiplier) between two requesters.
//  Examples: the multicycle core datapath and an FP coprocessor/DMA port.
//  Round-robin grants; operands are registered before the multiplier.
//  Runs one operation at a time. Each result goes back, tagged, to the requester that issued it.
// PARAMETERS
//  LAT  2  cycles in EXEC from operand capture to result capture (1..15)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req0_valid  in   1   requester 0 has an operation pending
//  req0_ready  out  1   requester 0 granted; handshake when valid&&ready at clk edge
//  req0_a      in   16  requester 0 operand A (IEEE-754 half)
//  req0_b      in   16  requester 0 operand B
//  req1_valid  in   1   requester 1 has an operation pending
//  req1_ready  out  1   requester 1 granted
//  req1_a      in   16  requester 1 operand A
//  req1_b      in   16  requester 1 operand B
//  rsp0_valid  out  1   one-cycle pulse: rsp0_data holds requester 0 result
//  rsp0_data   out  16  requester 0 product, held until next rsp0 pulse
//  rsp1_valid  out  1   one-cycle pulse for requester 1
//  rsp1_data   out  16  requester 1 product, held until next rsp1 pulse
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, rr=0, cnt=0.
//   - Operand regs, owner and rsp*_data = 0.
//   - All valid/ready outputs = 0; busy=0.
//   - Reset mid-operation drops the in-flight op: no rsp pulse, no data update.
//  FSM IDLE -> EXEC -> RESP -> IDLE. No other transitions.
//  IDLE:
//   - grant = rr if req[rr]_valid; else the other requester if it is valid; else none.
//   - req<grant>_ready=1, driven combinationally from state/rr/valids.
//   - At most one ready is high; ready=0 in every state other than IDLE.
//   - On handshake: capture a,b into op regs, owner<=grant, cnt<=LAT-1, state<=EXEC.
//  EXEC:
//   - fp_mul_16 is fed only from op regs, so requester inputs are ignored here.
//   - If cnt!=0: cnt<=cnt-1.
//   - If cnt==0: rsp<owner>_data <= product, state<=RESP.
//  RESP:
//   - rsp<owner>_valid=1 for exactly this cycle; the other rsp_valid stays 0.
//   - rr <= ~owner; state<=IDLE.
//  Timing:
//   - Handshake at edge k gives rsp valid in the cycle after edge k+LAT.
//   - Earliest next handshake is edge k+LAT+2. Throughput is 1 op per LAT+2 cycles.
//  Requester rules:
//   - Hold valid and operands stable until ready.
//   - Operands are sampled only at the handshake edge.
//   - Dropping valid before grant withdraws the request with no side effect.
//  Fairness: if both requesters are continuously valid, grants alternate strictly.
//  Arithmetic: fp_mul_16 semantics unchanged.
//   - Any operand with exponent 0 gives 16'h0000.
//   - Truncating mantissa.
//   - No NaN/Inf handling.
//   - sign = a[15]^b[15].
// TESTING (LAT=2)
//  1. Single request:
//     - Stimulus: req0 0x3E00*0x4000.
//     - Response: ready0 in IDLE; rsp0_valid pulses 3 cycles after handshake with 0x4200.
//     - rsp1_valid stays 0 throughout.
//  2. Simultaneous first requests after reset:
//     - Stimulus: req0 0x4000*0x4000 and req1 0xBC00*0x4000 both valid.
//     - Response: req0 granted first, rsp0=0x4400; then req1, rsp1=0xC000.
//  3. Fairness:
//     - Stimulus: both requesters held valid for 4 ops.
//     - Response: grant order 0,1,0,1; ready never high in EXEC/RESP; busy low only in IDLE.
//  4. Zero operand:
//     - Stimulus: req1 0x0000*0x4200.
//     - Response: rsp1_data=0x0000. rsp0_data keeps its previous value.
//  5. Reset mid-EXEC:
//     - Stimulus: assert reset one cycle after handshake.
//     - Response: all outputs 0 immediately (async); no rsp pulse.
//     - A following req0 0x3E00*0x4000 still returns 0x4200.
//  6. Operand change:
//     - Stimulus: change req0_a right after handshake.
//     - Response: result uses the value captured at the handshake edge.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one half-precision multiplier between two requesters.
// One operation in flight at a time; each result returns tagged to its issuer.
module fp_mul_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rr;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic [15:0] r_op_a_p0;
  logic [15:0] r_op_b_p0;
  logic [15:0] r_rsp0_data;
  logic [15:0] r_rsp1_data;
  logic [1:0]  w_req;
  logic        w_grant;
  logic        w_hs;
  logic [15:0] w_prod_p1;

  // Denormals flush to zero, mantissa truncates, exponent wraps (no Inf/NaN).
  function automatic logic [15:0] fp_mul16(input logic [15:0] a, input logic [15:0] b);
    logic [11:0] prod_hi;
    logic [4:0]  exp;
    logic [9:0]  man;
    logic [15:0] res;
    prod_hi = 12'(({11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]}) >> 10);
    exp     = a[14:10] + b[14:10] - 5'd15 + {4'd0, prod_hi[11]};
    man     = prod_hi[11] ? prod_hi[10:1] : prod_hi[9:0];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0)
      res = 16'h0000;
    else
      res = {a[15] ^ b[15], exp, man};
    return res;
  endfunction

  assign w_req     = {req1_valid, req0_valid};
  assign w_grant   = w_req[r_rr] ? r_rr : ~r_rr;
  assign w_hs      = (r_state == S_IDLE) && (w_req != 2'b00);
  assign w_prod_p1 = fp_mul16(r_op_a_p0, r_op_b_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (w_hs) begin
      req0_ready = ~w_grant;
      req1_ready = w_grant;
    end
    rsp0_valid = (r_state == S_RESP) && !r_owner;
    rsp1_valid = (r_state == S_RESP) && r_owner;
    busy       = (r_state != S_IDLE);
  end

  // p0: operands captured at handshake; p1: product captured when the count expires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_cnt       <= 4'd0;
      r_op_a_p0   <= 16'h0000;
      r_op_b_p0   <= 16'h0000;
      r_rsp0_data <= 16'h0000;
      r_rsp1_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op_a_p0 <= w_grant ? req1_a : req0_a;
            r_op_b_p0 <= w_grant ? req1_b : req0_b;
            r_owner   <= w_grant;
            r_cnt     <= 4'(LAT - 1);
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
          else if (r_owner)
            r_rsp1_data <= w_prod_p1;
          else
            r_rsp0_data <= w_prod_p1;
        end
        S_RESP:  r_rr <= ~r_owner;
        default: ;
      endcase
    end
  end

  assign rsp0_data = r_rsp0_data;
  assign rsp1_data = r_rsp1_data;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level timing/arithmetic model.
module tb_fp_mul_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp_mul_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Real-valued product, renormalised and truncated back to half precision.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    real v;
    int  e;
    logic [9:0] m;
    if (a[14:10] == 0 || b[14:10] == 0) return 16'h0000;
    v = (1.0 + real'(a[9:0]) / 1024.0) * (1.0 + real'(b[9:0]) / 1024.0);
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    while (v >= 2.0) begin
      v = v / 2.0;
      e++;
    end
    m = 10'($rtoi((v - 1.0) * 1024.0));
    return {a[15] ^ b[15], 5'(e), m};
  endfunction

  function automatic logic [15:0] rand_op();
    if ($urandom_range(7) == 0) return {1'($urandom), 5'd0, 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
  endfunction

  // Transaction-level model: one op per LAT+2 cycles, result due LAT+1 cycles after handshake.
  int          n, m_free_at, m_rsp_cyc;
  bit          m_pend, m_rr, m_own, g, idle, e_r0, e_r1, e_v0, e_v1;
  logic [15:0] m_res;
  logic [15:0] m_data [2];

  always @(negedge clk) begin
    if (reset) begin
      n = 0; m_free_at = 0; m_pend = 0; m_rr = 0;
      m_data[0] = 16'h0; m_data[1] = 16'h0;
      chk("reset_ctl", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 32'd0);
      chk("reset_data", {rsp0_data, rsp1_data}, 32'd0);
    end else begin
      idle = (n >= m_free_at);
      e_r0 = 0; e_r1 = 0; g = 0; e_v0 = 0; e_v1 = 0;
      if (idle && (req0_valid || req1_valid)) begin
        if (m_rr) g = req1_valid ? 1'b1 : 1'b0;
        else      g = req0_valid ? 1'b0 : 1'b1;
        e_r0 = !g; e_r1 = g;
      end
      if (m_pend && n == m_rsp_cyc) begin
        m_data[m_own] = m_res;
        m_pend = 0;
        if (m_own) e_v1 = 1; else e_v0 = 1;
      end
      chk("ready", {30'd0, req0_ready, req1_ready}, {30'd0, e_r0, e_r1});
      chk("busy", {31'd0, busy}, {31'd0, !idle});
      chk("rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, {30'd0, e_v0, e_v1});
      chk("rsp0_data", {16'd0, rsp0_data}, {16'd0, m_data[0]});
      chk("rsp1_data", {16'd0, rsp1_data}, {16'd0, m_data[1]});
      if (e_r0 || e_r1) begin
        m_pend    = 1;
        m_own     = g;
        m_res     = g ? ref_mul(req1_a, req1_b) : ref_mul(req0_a, req0_b);
        m_rsp_cyc = n + 1 + LAT;
        m_free_at = n + LAT + 2;
        m_rr      = !g;
      end
      n++;
    end
  end

  task automatic set_req(input int who, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (who == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else          begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic wait_hs(output int got);
    got = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin got = 0; break; end
      if (req1_valid && req1_ready) begin got = 1; break; end
    end
  endtask

  task automatic wait_rsp(input int who, output logic [15:0] d, output int lat);
    d = 16'hxxxx;
    lat = -1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (who == 0 && rsp0_valid) begin d = rsp0_data; lat = i; break; end
      if (who == 1 && rsp1_valid) begin d = rsp1_data; lat = i; break; end
    end
  endtask

  task automatic do_op(input int who, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expd, input string name);
    int got, lat;
    logic [15:0] d;
    set_req(who, 1'b1, a, b);
    wait_hs(got);
    chk({name, "_grant"}, got, who);
    @(posedge clk); #2;
    set_req(who, 1'b0, a ^ 16'h1234, b ^ 16'h0400);
    wait_rsp(who, d, lat);
    chk({name, "_lat"}, lat, LAT + 1);
    chk({name, "_data"}, {16'd0, d}, {16'd0, expd});
    @(posedge clk); #2;
  endtask

  initial begin
    int got, lat;
    logic [15:0] d;
    bit h0, h1;
    reset = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;

    chk("model_3e00x4000", {16'd0, ref_mul(16'h3E00, 16'h4000)}, 32'h4200);
    chk("model_4000x4000", {16'd0, ref_mul(16'h4000, 16'h4000)}, 32'h4400);
    chk("model_bc00x4000", {16'd0, ref_mul(16'hBC00, 16'h4000)}, 32'hC000);
    chk("model_zero",      {16'd0, ref_mul(16'h0000, 16'h4200)}, 32'h0000);
    chk("model_trunc",     {16'd0, ref_mul(16'h3FFF, 16'h3FFF)}, 32'h43FE);
    chk("model_tiny",      {16'd0, ref_mul(16'h3C01, 16'h3C01)}, 32'h3C02);

    // Both requesters held valid from reset: strict alternation starting at 0.
    set_req(0, 1'b1, 16'h4000, 16'h4000);
    set_req(1, 1'b1, 16'hBC00, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      wait_hs(got);
      chk("fair_order", got, i % 2);
      if (i == 3) begin
        @(posedge clk); #2;
        set_req(0, 1'b0, 16'h0, 16'h0);
        set_req(1, 1'b0, 16'h0, 16'h0);
      end
      wait_rsp(i % 2, d, lat);
      chk("fair_data", {16'd0, d}, (i % 2) ? 32'hC000 : 32'h4400);
    end
    @(posedge clk); #2;

    do_op(1, 16'h0000, 16'h4200, 16'h0000, "zero");
    chk("zero_keep_rsp0", {16'd0, rsp0_data}, 32'h4400);
    do_op(0, 16'h3E00, 16'h4000, 16'h4200, "single");

    // Reset one cycle into EXEC must kill the op outright.
    set_req(0, 1'b1, 16'h4000, 16'h4000);
    wait_hs(got);
    chk("rst_grant", got, 0);
    @(posedge clk); #2;
    set_req(0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_async", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 32'd0);
    chk("rst_async_data", {rsp0_data, rsp1_data}, 32'd0);
    @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    do_op(0, 16'h3E00, 16'h4000, 16'h4200, "after_rst");

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #2;
      if (req0_valid && !h0) begin
        if ($urandom_range(15) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(1) == 1) set_req(0, 1'b1, rand_op(), rand_op());
      else set_req(0, 1'b0, 16'($urandom), 16'($urandom));
      if (req1_valid && !h1) begin
        if ($urandom_range(15) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(1) == 1) set_req(1, 1'b1, rand_op(), rand_op());
      else set_req(1, 1'b0, 16'($urandom), 16'($urandom));
    end
    set_req(0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 16'h0, 16'h0);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
